// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and RAM depth.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        RESP
    } lsu_state_e;

    // Natural alignment check; byte accesses can never be misaligned.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset[0];
            SIZE_WORD: return offset != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extraction with sign/zero extension,
// and sub-word store merge into an existing RAM word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [4:0]  w_shamt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_wdata_rep;

    assign w_shamt = {i_offset, 3'b000};
    assign w_byte  = i_word[w_shamt +: 8];
    assign w_half  = i_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_load      = i_word;
        w_mask      = 32'h0000_0000;
        w_wdata_rep = 32'h0000_0000;
        case (i_size)
            SIZE_BYTE: begin
                o_load      = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                w_mask      = 32'h0000_00FF << w_shamt;
                w_wdata_rep = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                o_load      = {{16{~i_unsigned & w_half[15]}}, w_half};
                w_mask      = 32'h0000_FFFF << w_shamt;
                w_wdata_rep = {2{i_wdata}};
            end
            default: ;
        endcase
    end

    // Store data is replicated to every lane so the mask alone picks the target lane.
    assign o_merge = (i_word & ~w_mask) | (w_wdata_rep & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-organised RAM; sub-word stores
// are read-modify-write and bad accesses are answered with an error without touching RAM.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;

    logic        w_req_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_req_err = (req_size == SIZE_ILLEGAL)
                    || size_misaligned(req_size, req_addr[1:0])
                    || ({2'b00, req_addr[31:2]} >= MEM_WORDS);

    lsu_lane_align u_lane_align (
        .i_word     (mem_rdata),
        .i_wdata    (r_wdata[15:0]),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_write     <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_merge     <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_rdata     <= 32'h0;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_err <= 1'b0;
                            if (!req_write) begin
                                r_state <= LOAD;
                            end else if (req_size == SIZE_WORD) begin
                                r_state <= WRITE;
                            end else begin
                                r_state <= READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    r_rdata     <= w_load;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                READ: begin
                    r_merge <= w_merge;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // RAM side depends only on registered state, never on the live request.
    assign mem_addr  = {2'b00, r_addr[31:2]};
    assign mem_we    = (r_state == WRITE);
    assign mem_wdata = (r_state != WRITE)    ? 32'h0   :
                       (r_size == SIZE_WORD) ? r_wdata : r_merge;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts every
// response, a monitor checks responses, RAM writes, latency and stability.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
        logic [31:0] widx;
        int          acc;
    } exp_t;

    logic [31:0] ram [0:1023];
    logic [7:0]  ref_bytes [0:4095];
    exp_t        exp_q [$];
    exp_t        cur;
    bit          have_cur = 0;
    int          we_cnt = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          bp_mode = 0;
    int          checks = 0;
    int          errors = 0;

    assign mem_rdata = (mem_addr < 32'd1024) ? ram[mem_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        cyc++;
        if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model over a flat byte array; mutates memory for stores.
    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int n;
        int a;
        logic [63:0] v;
        n = 1 << sz;
        e.rdata = 32'h0;
        e.we    = 0;
        e.widx  = 32'h0;
        e.acc   = 0;
        e.err   = (sz == 2'd3) || ((addr % n) != 0) || ((addr >> 2) >= 1024);
        if (e.err) begin
            e.lat = 1;
        end else begin
            a = int'(addr);
            if (!wr) begin
                v = 64'h0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[a + i]) << (8 * i));
                if (!uns && n < 4 && v[8 * n - 1]) v = v | (~64'h0 << (8 * n));
                e.rdata = v[31:0];
                e.lat   = 2;
            end else begin
                for (int i = 0; i < n; i++) ref_bytes[a + i] = 8'(wd >> (8 * i));
                e.we   = 1;
                e.widx = addr >> 2;
                e.lat  = (n == 4) ? 2 : 3;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit track,
                         output int acc);
        exp_t e;
        int n;
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (track) begin
            e = model(wr, sz, uns, addr, wd);
            e.acc = acc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || rsp_valid) chk("idle_timeout", {31'b0, rsp_valid}, 32'd0);
    endtask

    always @(posedge clk) begin
        #2;
        if (bp_mode == 0) rsp_ready = 1'b1;
        else if (bp_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
        else rsp_ready = 1'b0;
    end

    // Monitor: pops one expectation per new response and checks it while it is held.
    always @(negedge clk) begin
        if (reset) begin
            have_cur = 0;
            we_cnt   = 0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                if (exp_q.size() == 0) chk("mem_we_unexpected", {31'b0, mem_we}, 32'd0);
                else chk("mem_addr", mem_addr, exp_q[0].widx);
            end
            if (rsp_valid) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        chk("rsp_rdata", rsp_rdata, cur.rdata);
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
                        chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                        chk("mem_we_cycles", 32'(we_cnt), 32'(cur.we));
                        we_cnt = 0;
                    end
                end else begin
                    chk("rdata_stable", rsp_rdata, cur.rdata);
                    chk("err_stable", {31'b0, rsp_err}, {31'b0, cur.err});
                    chk("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
                end
                if (rsp_ready) begin
                    have_cur = 0;
                    last_hs  = cyc + 1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int n;
        logic [31:0] v;
        logic [31:0] wexp;
        logic [1:0]  sz;
        logic [31:0] addr;

        for (int w = 0; w < 1024; w++) begin
            v = $urandom;
            ram[w] = v;
            for (int i = 0; i < 4; i++) ref_bytes[4 * w + i] = 8'(v >> (8 * i));
        end

        // Reset values
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        bp_mode = 0;

        // Directed sequence
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, acc);
        wait_idle();
        chk("ram4_after_sw", ram[4], 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b1, acc);
        wait_idle();
        chk("ram4_after_sb", ram[4], 32'hDEADA5EF);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, acc);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, acc);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 1'b1, acc);
        wait_idle();
        chk("ram4_after_sh", ram[4], 32'h1234A5EF);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, acc);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, acc);
        issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1'b1, acc);
        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, acc);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        wait_idle();
        chk("ram4_after_errors", ram[4], 32'h1234A5EF);

        // Backpressure: hold the load response, present a second request meanwhile
        bp_mode = 2;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        fork
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_rsp_seen", {31'b0, rsp_valid}, 32'd1);
                repeat (5) @(negedge clk);
                bp_mode = 0;
            end
            begin
                issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, acc2);
                chk("bp_accept_after_hs", {31'b0, acc2 > last_hs}, 32'd1);
            end
        join
        wait_idle();

        // Reset while a sub-word store sits in READ
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000077, 1'b0, acc);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
            chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
            chk("mid_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
            chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
            chk("mid_rst_mem_addr", mem_addr, 32'h0);
            chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("ram4_after_abort", ram[4], 32'h1234A5EF);

        // Randomised traffic with random response backpressure
        bp_mode = 1;
        for (int k = 0; k < 400; k++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                addr = ($urandom_range(0, 1) == 0) ? (32'd4096 + 32'($urandom_range(0, 31)))
                                                   : $urandom;
            end else begin
                addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom,
                  1'b1, acc);
        end
        bp_mode = 0;
        wait_idle();
        repeat (2) @(negedge clk);

        for (int w = 0; w < 1024; w++) begin
            wexp = {ref_bytes[4 * w + 3], ref_bytes[4 * w + 2],
                    ref_bytes[4 * w + 1], ref_bytes[4 * w]};
            chk("ram_final", ram[w], wexp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
